// File: rtl/operand_stage_pkg.sv
// Shared widths, operand-bundle type and helpers for the RV32 operand stage.
// Also the home of the ALU_OP encodings that alu_control decodes.
package operand_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned REG_AW   = $clog2(NREG);
  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned FUNC_W   = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    AluOpLoadStore = 2'b00,
    AluOpBranch    = 2'b01,
    AluOpRtype     = 2'b10,
    AluOpItype     = 2'b11
  } alu_op_e;

  // Contents of the output register toward the ALU.
  typedef struct packed {
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [REG_AW-1:0]   rd;
    logic                rd_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic [FUNC_W-1:0]   func_code;
  } op_bundle_t;

  // x0 is hardwired, so it never takes part in hazards or writes.
  function automatic logic live_idx(input logic [REG_AW-1:0] idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/operand_stage_reg_file.sv
// Integer register file: NREG x XLEN, two combinational read ports, one write port.
// x0 reads as zero; a same-cycle write is forwarded to the read ports.
module operand_stage_reg_file
  import operand_stage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  output logic [XLEN-1:0]   o_rd1,
  output logic [XLEN-1:0]   o_rd2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [XLEN-1:0]   i_wd
);

  logic [XLEN-1:0] r_mem [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && live_idx(i_wa)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd1 = r_mem[i_ra1];
    if (!live_idx(i_ra1)) begin
      o_rd1 = '0;
    end else if (i_we && i_wa == i_ra1) begin
      o_rd1 = i_wd;
    end
  end

  always_comb begin
    o_rd2 = r_mem[i_ra2];
    if (!live_idx(i_ra2)) begin
      o_rd2 = '0;
    end else if (i_we && i_wa == i_ra2) begin
      o_rd2 = i_wd;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register read, busy-bit scoreboard with RAW/WAW stall,
// and a single valid/ready output register feeding the ALU.
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [REG_AW-1:0]   i_rs1,
  input  logic [REG_AW-1:0]   i_rs2,
  input  logic [REG_AW-1:0]   i_rd,
  input  logic                i_rd_we,
  input  logic [XLEN-1:0]     i_imm,
  input  logic                i_use_imm,
  input  logic [ALU_OP_W-1:0] i_alu_op,
  input  logic [FUNC_W-1:0]   i_func_code,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [XLEN-1:0]     o_a,
  output logic [XLEN-1:0]     o_b,
  output logic [REG_AW-1:0]   o_rd,
  output logic                o_rd_we,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [FUNC_W-1:0]   o_func_code,
  input  logic                i_wb_en,
  input  logic [REG_AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0]     i_wb_data
);

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_clr;
  logic [NREG-1:0] w_busy_eff;
  logic [NREG-1:0] w_busy_d;
  logic            w_hazard;
  logic            w_accept;
  logic            r_valid;
  op_bundle_t      r_out;

  operand_stage_reg_file u_reg_file (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_ra1   (i_rs1),
    .i_ra2   (i_rs2),
    .o_rd1   (w_rs1_val),
    .o_rd2   (w_rs2_val),
    .i_we    (i_wb_en),
    .i_wa    (i_wb_addr),
    .i_wd    (i_wb_data)
  );

  always_comb begin
    w_busy_clr = '0;
    if (i_wb_en) begin
      w_busy_clr[i_wb_addr] = 1'b1;
    end
  end

  // A writeback landing this cycle releases its register in time for the issuing instruction.
  assign w_busy_eff = r_busy & ~w_busy_clr;

  assign w_hazard = (live_idx(i_rs1) && w_busy_eff[i_rs1])
                  || (!i_use_imm && live_idx(i_rs2) && w_busy_eff[i_rs2])
                  || (i_rd_we && live_idx(i_rd) && w_busy_eff[i_rd]);

  assign o_ready  = !w_hazard && !i_flush && (!r_valid || i_ready);
  assign w_accept = i_valid && o_ready;

  // Order matters: clears first, then the accepting instruction's set wins.
  always_comb begin
    w_busy_d = w_busy_eff;
    if (i_flush && r_valid && r_out.rd_we && live_idx(r_out.rd)) begin
      w_busy_d[r_out.rd] = 1'b0;
    end
    if (w_accept && i_rd_we && live_idx(i_rd)) begin
      w_busy_d[i_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_busy <= w_busy_d;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_out   <= '{a:         w_rs1_val,
                     b:         i_use_imm ? i_imm : w_rs2_val,
                     rd:        i_rd,
                     rd_we:     i_rd_we,
                     alu_op:    i_alu_op,
                     func_code: i_func_code};
      end else if (i_flush || i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_a         = r_out.a;
  assign o_b         = r_out.b;
  assign o_rd        = r_out.rd;
  assign o_rd_we     = r_out.rd_we;
  assign o_alu_op    = r_out.alu_op;
  assign o_func_code = r_out.func_code;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: expected bundles are queued at issue and popped when
// the output register presents them.
module tb_operand_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [4:0]  i_rd;
  logic        i_rd_we;
  logic [31:0] i_imm;
  logic        i_use_imm;
  logic [1:0]  i_alu_op;
  logic [5:0]  i_func_code;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic [4:0]  o_rd;
  logic        o_rd_we;
  logic [1:0]  o_alu_op;
  logic [5:0]  o_func_code;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rd_we;
    logic [1:0]  alu_op;
    logic [5:0]  func_code;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  operand_stage dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_rd        (i_rd),
    .i_rd_we     (i_rd_we),
    .i_imm       (i_imm),
    .i_use_imm   (i_use_imm),
    .i_alu_op    (i_alu_op),
    .i_func_code (i_func_code),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_rd        (o_rd),
    .o_rd_we     (o_rd_we),
    .o_alu_op    (o_alu_op),
    .o_func_code (o_func_code),
    .i_wb_en     (i_wb_en),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    i_valid     = 1'b0;
    i_rs1       = '0;
    i_rs2       = '0;
    i_rd        = '0;
    i_rd_we     = 1'b0;
    i_imm       = '0;
    i_use_imm   = 1'b1;
    i_alu_op    = '0;
    i_func_code = '0;
    i_flush     = 1'b0;
    i_wb_en     = 1'b0;
    i_wb_addr   = '0;
    i_wb_data   = '0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] imm, input logic use_imm,
                       input logic [1:0] op, input logic [5:0] fn);
    idle();
    i_valid     = 1'b1;
    i_rs1       = rs1;
    i_rs2       = rs2;
    i_rd        = rd;
    i_rd_we     = we;
    i_imm       = imm;
    i_use_imm   = use_imm;
    i_alu_op    = op;
    i_func_code = fn;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    i_wb_en   = 1'b1;
    i_wb_addr = addr;
    i_wb_data = data;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                      input logic we, input logic [1:0] op, input logic [5:0] fn);
    exp_t e;
    e.a = a; e.b = b; e.rd = rd; e.rd_we = we; e.alu_op = op; e.func_code = fn;
    q.push_back(e);
  endtask

  task automatic chk_fields(input string tag, input exp_t e);
    chk({tag, "_a"},      o_a, e.a);
    chk({tag, "_b"},      o_b, e.b);
    chk({tag, "_rd"},     32'(o_rd), 32'(e.rd));
    chk({tag, "_rd_we"},  32'(o_rd_we), 32'(e.rd_we));
    chk({tag, "_alu_op"}, 32'(o_alu_op), 32'(e.alu_op));
    chk({tag, "_func"},   32'(o_func_code), 32'(e.func_code));
  endtask

  task automatic expect_out(input string tag, input bit pop);
    exp_t e;
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    n_run++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = pop ? q.pop_front() : q[0];
      chk_fields(tag, e);
    end
  endtask

  initial begin
    idle();
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_valid",  32'(o_valid), 32'd0);
    chk("rst_a",      o_a, 32'd0);
    chk("rst_b",      o_b, 32'd0);
    chk("rst_rd",     32'(o_rd), 32'd0);
    chk("rst_rd_we",  32'(o_rd_we), 32'd0);
    chk("rst_alu_op", 32'(o_alu_op), 32'd0);
    chk("rst_func",   32'(o_func_code), 32'd0);
    chk("rst_ready",  32'(o_ready), 32'd1);
    i_rst_n = 1'b1;

    // Plain read of a written register with an immediate operand B.
    wb(5'd5, 32'h1234);
    tick();
    issue(5'd5, 5'd0, 5'd1, 1'b0, 32'h10, 1'b1, 2'd2, 6'h15);
    settle();
    chk("t1_ready", 32'(o_ready), 32'd1);
    push(32'h1234, 32'h10, 5'd1, 1'b0, 2'd2, 6'h15);
    tick();
    idle();
    expect_out("t1", 1'b1);
    tick();
    chk("t1_drain", 32'(o_valid), 32'd0);

    // RAW stall until the writeback, which is bypassed in the accepting cycle.
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'd5, 1'b1, 2'd0, 6'h00);
    settle();
    chk("t2_prod_ready", 32'(o_ready), 32'd1);
    push(32'd0, 32'd5, 5'd3, 1'b1, 2'd0, 6'h00);
    tick();
    expect_out("t2_prod", 1'b1);
    issue(5'd3, 5'd0, 5'd2, 1'b0, 32'd1, 1'b1, 2'd1, 6'h01);
    settle();
    chk("t2_stall0", 32'(o_ready), 32'd0);
    tick();
    chk("t2_stall_drain", 32'(o_valid), 32'd0);
    chk("t2_stall1", 32'(o_ready), 32'd0);
    tick();
    wb(5'd3, 32'hAA);
    settle();
    chk("t2_wb_ready", 32'(o_ready), 32'd1);
    push(32'hAA, 32'd1, 5'd2, 1'b0, 2'd1, 6'h01);
    tick();
    idle();
    expect_out("t2_cons", 1'b1);

    // x0 writes are discarded and x0 never becomes busy.
    wb(5'd0, 32'hFFFF);
    tick();
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h22, 1'b1, 2'd3, 6'h3F);
    settle();
    chk("t3_ready0", 32'(o_ready), 32'd1);
    push(32'd0, 32'h22, 5'd0, 1'b1, 2'd3, 6'h3F);
    tick();
    expect_out("t3_first", 1'b1);
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 1'b0, 2'd3, 6'h3F);
    settle();
    chk("t3_ready1", 32'(o_ready), 32'd1);
    push(32'd0, 32'd0, 5'd0, 1'b1, 2'd3, 6'h3F);
    tick();
    expect_out("t3_second", 1'b1);

    // Backpressure: held outputs stay stable for three cycles, then transfer.
    issue(5'd5, 5'd3, 5'd10, 1'b1, 32'h0, 1'b0, 2'd1, 6'h2A);
    settle();
    chk("t4_ready", 32'(o_ready), 32'd1);
    push(32'h1234, 32'hAA, 5'd10, 1'b1, 2'd1, 6'h2A);
    tick();
    i_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd0, 1'b0, 32'h99, 1'b1, 2'd0, 6'h00);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t4_bp_ready", 32'(o_ready), 32'd0);
      expect_out("t4_hold", 1'b0);
      tick();
    end
    i_ready = 1'b1;
    settle();
    chk("t4_release_ready", 32'(o_ready), 32'd1);
    expect_out("t4_release", 1'b1);
    push(32'd0, 32'h99, 5'd0, 1'b0, 2'd0, 6'h00);
    tick();
    expect_out("t4_next", 1'b1);

    // Flush kills the held instruction and releases its destination.
    issue(5'd0, 5'd0, 5'd7, 1'b1, 32'd7, 1'b1, 2'd2, 6'h07);
    settle();
    chk("t5_ready", 32'(o_ready), 32'd1);
    push(32'd0, 32'd7, 5'd7, 1'b1, 2'd2, 6'h07);
    tick();
    expect_out("t5_held", 1'b1);
    idle();
    i_flush = 1'b1;
    settle();
    chk("t5_flush_ready", 32'(o_ready), 32'd0);
    tick();
    chk("t5_flush_valid", 32'(o_valid), 32'd0);
    issue(5'd7, 5'd0, 5'd0, 1'b0, 32'h70, 1'b1, 2'd0, 6'h00);
    settle();
    chk("t5_no_stall", 32'(o_ready), 32'd1);
    push(32'd0, 32'h70, 5'd0, 1'b0, 2'd0, 6'h00);
    tick();
    expect_out("t5_after", 1'b1);

    // Same-cycle writeback clear and issue set on x9: the set survives.
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 1'b1, 2'd0, 6'h00);
    settle();
    chk("t6_first_ready", 32'(o_ready), 32'd1);
    push(32'd0, 32'd0, 5'd9, 1'b1, 2'd0, 6'h00);
    tick();
    expect_out("t6_first", 1'b1);
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'd5, 1'b1, 2'd0, 6'h00);
    wb(5'd9, 32'h99);
    settle();
    chk("t6_waw_ready", 32'(o_ready), 32'd1);
    push(32'd0, 32'd5, 5'd9, 1'b1, 2'd0, 6'h00);
    tick();
    expect_out("t6_second", 1'b1);
    issue(5'd9, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 2'd0, 6'h00);
    settle();
    chk("t6_set_wins", 32'(o_ready), 32'd0);

    // Asynchronous reset in the middle of the stall.
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",  32'(o_valid), 32'd0);
    chk("t6_rst_a",      o_a, 32'd0);
    chk("t6_rst_b",      o_b, 32'd0);
    chk("t6_rst_rd",     32'(o_rd), 32'd0);
    chk("t6_rst_rd_we",  32'(o_rd_we), 32'd0);
    chk("t6_rst_alu_op", 32'(o_alu_op), 32'd0);
    chk("t6_rst_func",   32'(o_func_code), 32'd0);
    chk("t6_rst_ready",  32'(o_ready), 32'd1);
    tick();
    i_rst_n = 1'b1;
    settle();
    chk("t6_post_rst_ready", 32'(o_ready), 32'd1);
    push(32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 6'h00);
    tick();
    idle();
    expect_out("t6_post_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
